// File: rtl/tree_sum_accumulator_if.sv
// rtl/tree_sum_accumulator_if.sv - beat input and result output handshake bundle
interface tree_sum_accumulator_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
);
    logic [DATA_W-1:0] in_data_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [ACC_W-1:0]  out_data_o;
    logic              out_valid_o;
    logic              out_ready_i;

    modport slave (
        input  in_data_i,
        input  in_valid_i,
        input  out_ready_i,
        output in_ready_o,
        output out_data_o,
        output out_valid_o
    );

    modport master (
        output in_data_i,
        output in_valid_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_data_o,
        input  out_valid_o
    );
endinterface

// File: rtl/tree_sum_accumulator.sv
// rtl/tree_sum_accumulator.sv - accumulates K tree-adder sums per tile into a registered result
module tree_sum_accumulator #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [CNT_W-1:0]     k_len_i,
    tree_sum_accumulator_if.slave bus,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     beat_cnt_o
);

    generate
        if (ACC_W < DATA_W) begin : g_width_check
            $fatal(1, "tree_sum_accumulator: ACC_W must be >= DATA_W");
        end
    endgenerate

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t               state_q;
    state_t               state_d;
    logic [ACC_W-1:0]     acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     len_q;
    logic [ACC_W-1:0]     out_data_q;
    logic                 out_valid_q;

    logic                 in_ready;
    logic                 accept;
    logic                 is_last;
    logic [CNT_W-1:0]     eff_len;
    logic [CNT_W-1:0]     cnt_inc;
    logic signed [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0]     acc_base;
    logic [ACC_W-1:0]     sum;

    // Beat datapath: length resolution, last-beat detection and the running sum.
    // In IDLE the partial sum is treated as zero so a length-1 tile needs no special path.
    always_comb begin
        eff_len  = (k_len_i == '0) ? CNT_W'(1) : k_len_i;
        cnt_inc  = cnt_q + CNT_W'(1);
        in_ext   = ACC_W'($signed(bus.in_data_i));
        acc_base = (state_q == IDLE) ? '0 : acc_q;
        sum      = acc_base + ACC_W'(in_ext);
        accept   = bus.in_valid_i && in_ready;
        is_last  = (state_q == IDLE) ? (eff_len == CNT_W'(1)) : (cnt_inc == len_q);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter ACCUM on a non-final first beat, leave on the final beat or abort.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = is_last ? IDLE : ACCUM;
        end
    end

    // FSM outputs: acceptance is combinational so the last beat of a tile can land
    // in the same cycle the previous result drains.
    always_comb begin
        busy_o   = (state_q == ACCUM);
        in_ready = !clear_i && (!out_valid_q || bus.out_ready_i);
    end

    // Accumulator, beat counter, tile length and output register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (clear_i) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept && state_q == IDLE) begin
                len_q <= eff_len;
            end
            if (accept && is_last) begin
                out_data_q  <= sum;
                out_valid_q <= 1'b1;
                acc_q       <= '0;
                cnt_q       <= '0;
            end else begin
                if (accept) begin
                    acc_q <= sum;
                    cnt_q <= cnt_inc;
                end
                if (out_valid_q && bus.out_ready_i) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_valid_o = out_valid_q;
    assign beat_cnt_o      = cnt_q;

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// tb/tb_tree_sum_accumulator.sv - directed self-checking bench for tree_sum_accumulator
module tb_tree_sum_accumulator;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 32;
    localparam int CNT_W  = 16;

    logic             clk_i;
    logic             rst_ni;
    logic             clear_i;
    logic [CNT_W-1:0] k_len_i;
    logic             busy_o;
    logic [CNT_W-1:0] beat_cnt_o;

    int total_cnt;
    int pass_cnt;
    int result_cnt;

    tree_sum_accumulator_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    tree_sum_accumulator #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .k_len_i   (k_len_i),
        .bus       (bus.slave),
        .busy_o    (busy_o),
        .beat_cnt_o(beat_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [DATA_W-1:0] data);
        bus.in_valid_i = valid;
        bus.in_data_i  = data;
        #1;
    endtask

    initial begin
        total_cnt        = 0;
        pass_cnt         = 0;
        result_cnt       = 0;
        rst_ni           = 1'b0;
        clear_i          = 1'b0;
        k_len_i          = '0;
        bus.in_valid_i   = 1'b0;
        bus.in_data_i    = '0;
        bus.out_ready_i  = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", bus.out_valid_o, 0);
        check("rst_out_data", bus.out_data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_beat_cnt", beat_cnt_o, 0);
        check("rst_in_ready", bus.in_ready_o, 1);
        tick();
        rst_ni = 1'b1;
        tick();

        // Basic tile: 5 - 3 + 10 + 7 = 19
        k_len_i = 16'd4;
        drive(1'b1, 32'd5);
        check("basic_in_ready", bus.in_ready_o, 1);
        tick();
        check("basic_busy1", busy_o, 1);
        check("basic_cnt1", beat_cnt_o, 1);
        drive(1'b1, -32'sd3);
        tick();
        check("basic_cnt2", beat_cnt_o, 2);
        drive(1'b1, 32'd10);
        tick();
        check("basic_cnt3", beat_cnt_o, 3);
        check("basic_busy3", busy_o, 1);
        check("basic_no_valid_yet", bus.out_valid_o, 0);
        drive(1'b1, 32'd7);
        tick();
        check("basic_valid", bus.out_valid_o, 1);
        check("basic_data", bus.out_data_o, 19);
        check("basic_busy_done", busy_o, 0);
        check("basic_cnt_done", beat_cnt_o, 0);
        drive(1'b0, 32'd0);
        tick();
        check("basic_drained", bus.out_valid_o, 0);

        // Length 0 acts as length 1
        k_len_i = 16'd0;
        drive(1'b1, -32'sd42);
        tick();
        check("len0_valid", bus.out_valid_o, 1);
        check("len0_data", bus.out_data_o, 32'hFFFF_FFD6);
        check("len0_busy", busy_o, 0);
        drive(1'b0, 32'd0);
        tick();

        // Backpressure: first result 3 + 4 = 7 held, then tile 2 + 2 = 4
        k_len_i         = 16'd2;
        bus.out_ready_i = 1'b0;
        drive(1'b1, 32'd3);
        tick();
        drive(1'b1, 32'd4);
        tick();
        check("bp_first_valid", bus.out_valid_o, 1);
        check("bp_first_data", bus.out_data_o, 7);
        drive(1'b1, 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready_low", bus.in_ready_o, 0);
            tick();
            check("bp_data_stable", bus.out_data_o, 7);
            check("bp_valid_held", bus.out_valid_o, 1);
            check("bp_cnt_hold", beat_cnt_o, 0);
        end
        bus.out_ready_i = 1'b1;
        #1;
        check("bp_release_ready", bus.in_ready_o, 1);
        tick();
        check("bp_drained", bus.out_valid_o, 0);
        check("bp_cnt1", beat_cnt_o, 1);
        drive(1'b1, 32'd2);
        tick();
        check("bp_second_valid", bus.out_valid_o, 1);
        check("bp_second_data", bus.out_data_o, 4);
        drive(1'b0, 32'd0);
        tick();

        // Back-to-back: eight beats of 1, length 2, four results of 2
        k_len_i = 16'd2;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'd1);
            check("b2b_in_ready", bus.in_ready_o, 1);
            tick();
            if (bus.out_valid_o) begin
                result_cnt++;
                check("b2b_data", bus.out_data_o, 2);
            end
            check("b2b_valid_phase", bus.out_valid_o, ((i % 2) == 0) ? 1 : 0);
        end
        check("b2b_result_count", result_cnt, 4);
        drive(1'b0, 32'd0);
        tick();

        // Wrap-around
        k_len_i = 16'd2;
        drive(1'b1, 32'h7FFF_FFFF);
        tick();
        drive(1'b1, 32'd1);
        tick();
        check("wrap_data", bus.out_data_o, 32'h8000_0000);
        drive(1'b0, 32'd0);
        tick();

        // Abort with clear after two of four beats
        k_len_i = 16'd4;
        drive(1'b1, 32'd1);
        tick();
        drive(1'b1, 32'd1);
        tick();
        check("abort_cnt_before", beat_cnt_o, 2);
        clear_i = 1'b1;
        drive(1'b1, 32'd1);
        check("abort_in_ready", bus.in_ready_o, 0);
        tick();
        clear_i = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_cnt", beat_cnt_o, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'd1);
            tick();
        end
        check("abort_next_valid", bus.out_valid_o, 1);
        check("abort_next_data", bus.out_data_o, 4);
        drive(1'b0, 32'd0);
        tick();

        // Clear drops a pending result even with out_ready high
        k_len_i = 16'd1;
        drive(1'b1, 32'd6);
        tick();
        drive(1'b0, 32'd0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clear_drop_valid", bus.out_valid_o, 0);

        // Asynchronous reset mid-tile
        k_len_i = 16'd4;
        drive(1'b1, 32'd1);
        tick();
        drive(1'b1, 32'd1);
        tick();
        drive(1'b0, 32'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid_o, 0);
        check("arst_out_data", bus.out_data_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_cnt", beat_cnt_o, 0);
        tick();
        rst_ni = 1'b1;
        k_len_i = 16'd1;
        drive(1'b1, 32'd9);
        tick();
        check("arst_first_tile", bus.out_data_o, 9);
        drive(1'b0, 32'd0);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
